rle_encoder: RTL and testbench

- Run-length encoder stage of the RLE path.
- Consumes the serial bit stream produced by the toggle flip-flop stage, one bit per accepted cycle, and emits (bit value, run length) tokens over a valid/ready interface.
- Runs are closed by a value change, by counter saturation, or by an end-of-stream marker.
- Downstream is the RLE packer/serializer.

---
 rtl/rle_pkg.sv | 22 ++
 rtl/rle_run_counter.sv | 48 ++++
 rtl/rle_encoder.sv | 190 +++++++++++++++++++
 tb/tb_rle_encoder.sv | 308 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rle_pkg.sv
// Shared types for the RLE path: encoder FSM states, default run-length
// width and the (bit, count, last) token handed to the downstream packer.
package rle_pkg;

    // Default width of the run-length field; maximum run is 2^W - 1.
    localparam int unsigned RLE_COUNT_W = 8;

    // Encoder states: no open run, open run, final single-bit token pending.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2
    } rle_state_e;

    // Token as seen by the packer (at the default run-length width).
    typedef struct packed {
        logic                   bit_val;
        logic [RLE_COUNT_W-1:0] count;
        logic                   last;
    } rle_token_t;

endpackage

// File: rtl/rle_run_counter.sv
// Saturating run-length counter. clear wins over load_one, which wins over
// incr. at_max flags that the open run cannot be extended any further.
module rle_run_counter
    import rle_pkg::*;
#(
    parameter int unsigned COUNT_W = RLE_COUNT_W
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               clear,
    input  logic               load_one,
    input  logic               incr,
    output logic [COUNT_W-1:0] count,
    output logic               at_max
);

    localparam logic [COUNT_W-1:0] MAX_COUNT = {COUNT_W{1'b1}};

    logic [COUNT_W-1:0] count_d;
    logic [COUNT_W-1:0] count_q;

    // Next count: clear, restart at one, or saturating increment.
    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = {COUNT_W{1'b0}};
        end else if (load_one) begin
            count_d = COUNT_W'(1);
        end else if (incr && (count_q != MAX_COUNT)) begin
            count_d = count_q + COUNT_W'(1);
        end else begin
            count_d = count_q;
        end
    end

    // Count register, discarded on reset.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            count_q <= {COUNT_W{1'b0}};
        end else begin
            count_q <= count_d;
        end
    end

    assign count  = count_q;
    assign at_max = (count_q == MAX_COUNT);

endmodule

// File: rtl/rle_encoder.sv
// Run-length encoder: turns an accepted bit stream into (bit, run length,
// last) tokens. Runs close on a value change, on counter saturation or on
// the end-of-stream marker; the output token is held in a single register
// slot that is refilled in the same cycle it is drained.
module rle_encoder
    import rle_pkg::*;
#(
    parameter int unsigned COUNT_W = RLE_COUNT_W
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               in_valid,
    input  logic               in_bit,
    input  logic               in_last,
    output logic               in_ready,
    output logic               out_valid,
    output logic               out_bit,
    output logic [COUNT_W-1:0] out_count,
    output logic               out_last,
    input  logic               out_ready
);

    localparam logic [COUNT_W-1:0] MAX_COUNT = {COUNT_W{1'b1}};

    rle_state_e         state_d, state_q;
    logic               run_bit_d, run_bit_q;
    logic               pend_bit_d, pend_bit_q;
    logic               out_valid_d, out_valid_q;
    logic               out_bit_d, out_bit_q;
    logic [COUNT_W-1:0] out_count_d, out_count_q;
    logic               out_last_d, out_last_q;

    logic               slot_free_s;
    logic               accept_s;
    logic               same_bit_s;
    logic               cnt_clear_s;
    logic               cnt_load_s;
    logic               cnt_incr_s;
    logic [COUNT_W-1:0] run_count_s;
    logic               run_at_max_s;
    logic               emit_s;
    logic               emit_bit_s;
    logic [COUNT_W-1:0] emit_count_s;
    logic               emit_last_s;

    rle_run_counter #(
        .COUNT_W (COUNT_W)
    ) u_run_counter (
        .clock    (clock),
        .reset    (reset),
        .clear    (cnt_clear_s),
        .load_one (cnt_load_s),
        .incr     (cnt_incr_s),
        .count    (run_count_s),
        .at_max   (run_at_max_s)
    );

    // The slot can take a new token when empty or being drained this cycle.
    assign slot_free_s = !out_valid_q || out_ready;
    assign in_ready    = slot_free_s && (state_q != FLUSH) && !reset;
    assign accept_s    = in_valid && in_ready;
    assign same_bit_s  = (in_bit == run_bit_q);

    // Next-state logic: run bookkeeping and which token (if any) to emit.
    always_comb begin
        state_d      = state_q;
        run_bit_d    = run_bit_q;
        pend_bit_d   = pend_bit_q;
        cnt_clear_s  = 1'b0;
        cnt_load_s   = 1'b0;
        cnt_incr_s   = 1'b0;
        emit_s       = 1'b0;
        emit_bit_s   = 1'b0;
        emit_count_s = {COUNT_W{1'b0}};
        emit_last_s  = 1'b0;
        case (state_q)
            IDLE: begin
                if (accept_s) begin
                    if (in_last) begin
                        // Single-bit stream: emit immediately, no run opened.
                        emit_s       = 1'b1;
                        emit_bit_s   = in_bit;
                        emit_count_s = COUNT_W'(1);
                        emit_last_s  = 1'b1;
                    end else begin
                        run_bit_d  = in_bit;
                        cnt_load_s = 1'b1;
                        state_d    = RUN;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            RUN: begin
                if (accept_s) begin
                    if (same_bit_s && !run_at_max_s) begin
                        if (in_last) begin
                            emit_s       = 1'b1;
                            emit_bit_s   = run_bit_q;
                            emit_count_s = run_count_s + COUNT_W'(1);
                            emit_last_s  = 1'b1;
                            cnt_clear_s  = 1'b1;
                            state_d      = IDLE;
                        end else begin
                            cnt_incr_s = 1'b1;
                        end
                    end else begin
                        // Run closes by saturation or value change; the
                        // incoming bit starts a new run of one.
                        emit_s       = 1'b1;
                        emit_bit_s   = run_bit_q;
                        emit_count_s = same_bit_s ? MAX_COUNT : run_count_s;
                        emit_last_s  = 1'b0;
                        if (in_last) begin
                            // Slot is now full, so the final bit waits a cycle.
                            pend_bit_d  = in_bit;
                            cnt_clear_s = 1'b1;
                            state_d     = FLUSH;
                        end else begin
                            run_bit_d  = in_bit;
                            cnt_load_s = 1'b1;
                        end
                    end
                end else begin
                    state_d = RUN;
                end
            end
            FLUSH: begin
                if (slot_free_s) begin
                    emit_s       = 1'b1;
                    emit_bit_s   = pend_bit_q;
                    emit_count_s = COUNT_W'(1);
                    emit_last_s  = 1'b1;
                    state_d      = IDLE;
                end else begin
                    state_d = FLUSH;
                end
            end
            default: begin
                cnt_clear_s = 1'b1;
                state_d     = IDLE;
            end
        endcase
    end

    // Output slot: load a new token, drain on handshake, otherwise hold.
    always_comb begin
        out_valid_d = out_valid_q;
        out_bit_d   = out_bit_q;
        out_count_d = out_count_q;
        out_last_d  = out_last_q;
        if (emit_s) begin
            out_valid_d = 1'b1;
            out_bit_d   = emit_bit_s;
            out_count_d = emit_count_s;
            out_last_d  = emit_last_s;
        end else if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end else begin
            out_valid_d = out_valid_q;
        end
    end

    // State, run value and output slot registers.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            run_bit_q   <= 1'b0;
            pend_bit_q  <= 1'b0;
            out_valid_q <= 1'b0;
            out_bit_q   <= 1'b0;
            out_count_q <= {COUNT_W{1'b0}};
            out_last_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            run_bit_q   <= run_bit_d;
            pend_bit_q  <= pend_bit_d;
            out_valid_q <= out_valid_d;
            out_bit_q   <= out_bit_d;
            out_count_q <= out_count_d;
            out_last_q  <= out_last_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_bit   = out_bit_q;
    assign out_count = out_count_q;
    assign out_last  = out_last_q;

endmodule

// File: tb/tb_rle_encoder.sv
// Directed bench for rle_encoder: one instance at COUNT_W=8, one at
// COUNT_W=3. Consumed tokens are captured into queues and compared against
// hand-computed token lists.
module tb_rle_encoder;
    import rle_pkg::*;

    logic       clock = 1'b0;
    logic       reset;
    logic       out_ready;

    logic       iv8, ib8, il8, rdy8, ov8, ob8, ol8;
    logic [7:0] oc8;
    logic       iv3, ib3, il3, rdy3, ov3, ob3, ol3;
    logic [2:0] oc3;

    int checks = 0;
    int errors = 0;

    rle_token_t q8[$];
    rle_token_t q3[$];

    rle_encoder #(.COUNT_W(8)) dut8 (
        .clock(clock), .reset(reset),
        .in_valid(iv8), .in_bit(ib8), .in_last(il8), .in_ready(rdy8),
        .out_valid(ov8), .out_bit(ob8), .out_count(oc8), .out_last(ol8),
        .out_ready(out_ready)
    );

    rle_encoder #(.COUNT_W(3)) dut3 (
        .clock(clock), .reset(reset),
        .in_valid(iv3), .in_bit(ib3), .in_last(il3), .in_ready(rdy3),
        .out_valid(ov3), .out_bit(ob3), .out_count(oc3), .out_last(ol3),
        .out_ready(out_ready)
    );

    always #5 clock = ~clock;

    // Capture tokens that will be consumed at the next rising edge.
    always @(negedge clock) begin
        if (!reset) begin
            if (ov8 && out_ready) q8.push_back({ob8, oc8, ol8});
            if (ov3 && out_ready) q3.push_back({ob3, 5'b00000, oc3, ol3});
        end
    end

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clock);
            #1;
        end
    endtask

    // Present one bit to the selected instance and hold it until accepted.
    task automatic send(input int w, input logic b, input logic last);
        int n = 0;
        while ((((w == 8) ? rdy8 : rdy3) !== 1'b1) && (n < 100)) begin
            @(posedge clock);
            #1;
            n++;
        end
        if (n >= 100) begin
            checks++;
            errors++;
            $display("FAIL send_timeout w=%0d got in_ready=0 exp 1", w);
        end else begin
            if (w == 8) begin
                iv8 = 1'b1; ib8 = b; il8 = last;
            end else begin
                iv3 = 1'b1; ib3 = b; il3 = last;
            end
            @(posedge clock);
            #1;
            iv8 = 1'b0; il8 = 1'b0;
            iv3 = 1'b0; il3 = 1'b0;
        end
    endtask

    task automatic test_reset();
        checks++;
        if ({ov8, ob8, oc8, ol8, rdy8} !== 12'h000) begin
            errors++;
            $display("FAIL reset8 got %h exp 000", {ov8, ob8, oc8, ol8, rdy8});
        end
        checks++;
        if ({ov3, ob3, oc3, ol3, rdy3} !== 7'h00) begin
            errors++;
            $display("FAIL reset3 got %h exp 00", {ov3, ob3, oc3, ol3, rdy3});
        end
    endtask

    task automatic test_basic();
        rle_token_t exp [2] = '{{1'b0, 8'd3, 1'b0}, {1'b1, 8'd2, 1'b1}};
        logic [4:0] bits = 5'b11000;
        q8.delete();
        for (int i = 0; i < 5; i++) begin
            send(8, bits[i], (i == 4) ? 1'b1 : 1'b0);
            checks++;
            if (rdy8 !== 1'b1) begin
                errors++;
                $display("FAIL basic_in_ready bit%0d got %b exp 1", i, rdy8);
            end
        end
        tick(3);
        checks++;
        if (q8.size() != 2) begin
            errors++;
            $display("FAIL basic_ntok got %0d exp 2", q8.size());
        end else begin
            for (int i = 0; i < 2; i++) begin
                checks++;
                if (q8[i] !== exp[i]) begin
                    errors++;
                    $display("FAIL basic_tok%0d got %h exp %h", i, q8[i], exp[i]);
                end
            end
        end
    endtask

    task automatic test_saturate();
        rle_token_t exp [2] = '{{1'b1, 8'd7, 1'b0}, {1'b1, 8'd3, 1'b1}};
        q3.delete();
        for (int i = 0; i < 10; i++) send(3, 1'b1, (i == 9) ? 1'b1 : 1'b0);
        tick(3);
        checks++;
        if (q3.size() != 2) begin
            errors++;
            $display("FAIL sat_ntok got %0d exp 2", q3.size());
        end else begin
            for (int i = 0; i < 2; i++) begin
                checks++;
                if (q3[i] !== exp[i]) begin
                    errors++;
                    $display("FAIL sat_tok%0d got %h exp %h", i, q3[i], exp[i]);
                end
            end
        end
    endtask

    task automatic test_single();
        q8.delete();
        send(8, 1'b1, 1'b1);
        checks++;
        if ({ov8, ob8, oc8, ol8} !== {1'b1, 1'b1, 8'd1, 1'b1}) begin
            errors++;
            $display("FAIL single_tok got %h exp %h", {ov8, ob8, oc8, ol8}, {1'b1, 1'b1, 8'd1, 1'b1});
        end
        checks++;
        if (rdy8 !== 1'b1) begin
            errors++;
            $display("FAIL single_in_ready got %b exp 1", rdy8);
        end
        tick(2);
        checks++;
        if (q8.size() != 1) begin
            errors++;
            $display("FAIL single_ntok got %0d exp 1", q8.size());
        end
    endtask

    task automatic test_flush();
        rle_token_t exp8 [2] = '{{1'b1, 8'd2, 1'b0}, {1'b0, 8'd1, 1'b1}};
        rle_token_t exp3 [2] = '{{1'b1, 8'd7, 1'b0}, {1'b1, 8'd1, 1'b1}};
        q8.delete();
        q3.delete();
        send(8, 1'b1, 1'b0);
        send(8, 1'b1, 1'b0);
        send(8, 1'b0, 1'b1);
        checks++;
        if (rdy8 !== 1'b0) begin
            errors++;
            $display("FAIL flush_in_ready got %b exp 0", rdy8);
        end
        tick(1);
        checks++;
        if (rdy8 !== 1'b1) begin
            errors++;
            $display("FAIL flush_in_ready_after got %b exp 1", rdy8);
        end
        tick(2);
        checks++;
        if (q8.size() != 2) begin
            errors++;
            $display("FAIL flush8_ntok got %0d exp 2", q8.size());
        end else begin
            for (int i = 0; i < 2; i++) begin
                checks++;
                if (q8[i] !== exp8[i]) begin
                    errors++;
                    $display("FAIL flush8_tok%0d got %h exp %h", i, q8[i], exp8[i]);
                end
            end
        end
        for (int i = 0; i < 8; i++) send(3, 1'b1, (i == 7) ? 1'b1 : 1'b0);
        checks++;
        if (rdy3 !== 1'b0) begin
            errors++;
            $display("FAIL flush3_in_ready got %b exp 0", rdy3);
        end
        tick(3);
        checks++;
        if (q3.size() != 2) begin
            errors++;
            $display("FAIL flush3_ntok got %0d exp 2", q3.size());
        end else begin
            for (int i = 0; i < 2; i++) begin
                checks++;
                if (q3[i] !== exp3[i]) begin
                    errors++;
                    $display("FAIL flush3_tok%0d got %h exp %h", i, q3[i], exp3[i]);
                end
            end
        end
    endtask

    task automatic test_backpressure();
        rle_token_t exp [2] = '{{1'b0, 8'd2, 1'b0}, {1'b1, 8'd3, 1'b1}};
        q8.delete();
        out_ready = 1'b0;
        send(8, 1'b0, 1'b0);
        send(8, 1'b0, 1'b0);
        send(8, 1'b1, 1'b0);
        for (int i = 0; i < 5; i++) begin
            checks++;
            if ({ov8, ob8, oc8, rdy8} !== {1'b1, 1'b0, 8'd2, 1'b0}) begin
                errors++;
                $display("FAIL bp_hold cyc%0d got %h exp %h", i, {ov8, ob8, oc8, rdy8}, {1'b1, 1'b0, 8'd2, 1'b0});
            end
            tick(1);
        end
        checks++;
        if (q8.size() != 0) begin
            errors++;
            $display("FAIL bp_early_tok got %0d exp 0", q8.size());
        end
        out_ready = 1'b1;
        send(8, 1'b1, 1'b0);
        send(8, 1'b1, 1'b1);
        tick(3);
        checks++;
        if (q8.size() != 2) begin
            errors++;
            $display("FAIL bp_ntok got %0d exp 2", q8.size());
        end else begin
            for (int i = 0; i < 2; i++) begin
                checks++;
                if (q8[i] !== exp[i]) begin
                    errors++;
                    $display("FAIL bp_tok%0d got %h exp %h", i, q8[i], exp[i]);
                end
            end
        end
    endtask

    task automatic test_reset_midrun();
        rle_token_t exp = {1'b1, 8'd2, 1'b1};
        q8.delete();
        for (int i = 0; i < 4; i++) send(8, 1'b0, 1'b0);
        reset = 1'b1;
        #1;
        checks++;
        if ({ov8, rdy8} !== 2'b00) begin
            errors++;
            $display("FAIL rst_async got %b exp 00", {ov8, rdy8});
        end
        tick(2);
        reset = 1'b0;
        tick(1);
        checks++;
        if (q8.size() != 0 || ov8 !== 1'b0) begin
            errors++;
            $display("FAIL rst_no_tok got ntok=%0d valid=%b exp 0 0", q8.size(), ov8);
        end
        send(8, 1'b1, 1'b0);
        send(8, 1'b1, 1'b1);
        tick(3);
        checks++;
        if (q8.size() != 1) begin
            errors++;
            $display("FAIL rst_ntok got %0d exp 1", q8.size());
        end else begin
            checks++;
            if (q8[0] !== exp) begin
                errors++;
                $display("FAIL rst_tok got %h exp %h", q8[0], exp);
            end
        end
    endtask

    initial begin
        reset = 1'b1;
        out_ready = 1'b1;
        iv8 = 1'b0; ib8 = 1'b0; il8 = 1'b0;
        iv3 = 1'b0; ib3 = 1'b0; il3 = 1'b0;
        tick(2);
        test_reset();
        reset = 1'b0;
        tick(1);
        test_basic();
        test_saturate();
        test_single();
        test_flush();
        test_backpressure();
        test_reset_midrun();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
